// File: rtl/recon_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : recon_tx_framer
//  Purpose  : Transmit framer for the reconfiguration protocol. Prepends the
//             46-byte Eth/IP/RMT header and the 10-byte recon header to the
//             DMA payload stream, realigning payload by 8 bytes per beat.
//             Optional feature macro: RECON_TX_LEN_CHECK_EN (payload length
//             vs. requested size check, reported on status_err).
//  Revision : 1.0 - initial release
// ============================================================================
module recon_tx_framer #(
    parameter int DATA_WIDTH      = 512,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH      = 34,
    parameter int ETH_HDR_BYTES   = 46,
    parameter int RECON_HDR_BYTES = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_req_valid,
    output logic                       s_req_ready,
    input  logic [ETH_HDR_BYTES*8-1:0] s_req_eth_hdr,
    input  logic [1:0]                 s_req_func,
    input  logic                       s_req_size_valid,
    input  logic [ADDR_WIDTH-1:0]      s_req_addr,
    input  logic [7:0]                 s_req_id,
    input  logic [31:0]                s_req_size,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       status_frame_done,
    output logic                       status_err
);

    localparam int c_ETH_BITS    = ETH_HDR_BYTES * 8;
    localparam int c_RHDR_BITS   = RECON_HDR_BYTES * 8;
    localparam int c_HDR_BYTES   = ETH_HDR_BYTES + RECON_HDR_BYTES;
    localparam int c_HDR_BITS    = c_HDR_BYTES * 8;
    // Bytes of each payload beat that fit behind the saved 56 bytes
    localparam int c_SPILL_BYTES = KEEP_WIDTH - c_HDR_BYTES;
    localparam int c_SPILL_BITS  = c_SPILL_BYTES * 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR_ONLY = 3'd1;
    localparam logic [2:0] S_FIRST    = 3'd2;
    localparam logic [2:0] S_BODY     = 3'd3;
    localparam logic [2:0] S_TAIL     = 3'd4;

    // Recon header layout: {3'b0, size, id, addr(34), size_valid, func}
    function automatic logic [c_RHDR_BITS-1:0] f_pack_recon(
        input logic [1:0]            func,
        input logic                  size_valid,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            id,
        input logic [31:0]           size
    );
        logic [33:0] addr34;
        addr34 = 34'(addr);
        return {3'b000, size, id, addr34, size_valid, func};
    endfunction

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic [c_ETH_BITS-1:0]     r_eth;
    logic [c_RHDR_BITS-1:0]    r_recon;
    logic [c_HDR_BITS-1:0]     r_save;
    logic [c_HDR_BYTES-1:0]    r_save_keep;
    logic [DATA_WIDTH-1:0]     r_m_tdata;
    logic [KEEP_WIDTH-1:0]     r_m_tkeep;
    logic                      r_m_tvalid;
    logic                      r_m_tlast;
    logic                      r_err;

    logic                      w_slot;
    logic                      w_req_fire;
    logic                      w_pay_fire;
    logic                      w_rest_empty;
    logic                      w_len_err;
    logic [c_RHDR_BITS-1:0]    w_recon_in;

    assign w_slot       = !r_m_tvalid || m_axis_tready;
    assign w_req_fire   = s_req_valid && s_req_ready;
    assign w_pay_fire   = s_axis_tvalid && s_axis_tready;
    assign w_rest_empty = (s_axis_tkeep[KEEP_WIDTH-1:c_SPILL_BYTES] == '0);
    assign w_recon_in   = f_pack_recon(s_req_func, s_req_size_valid, s_req_addr,
                                       s_req_id, s_req_size);

`ifdef RECON_TX_LEN_CHECK_EN
    logic [31:0] r_size;
    logic [31:0] r_len_cnt;
    logic [31:0] w_beat_bytes;
    logic [31:0] w_len_sum;

    // Count the valid bytes in the current payload beat
    always_comb begin
        w_beat_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_beat_bytes = w_beat_bytes + 32'(s_axis_tkeep[i]);
        end
    end

    assign w_len_sum = r_len_cnt + w_beat_bytes;
    assign w_len_err = w_pay_fire && s_axis_tlast && (w_len_sum != r_size);

    // Per-frame payload byte counter, cleared on each accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_cnt <= '0;
            r_size    <= '0;
        end else if (w_req_fire) begin
            r_len_cnt <= '0;
            r_size    <= s_req_size;
        end else if (w_pay_fire) begin
            r_len_cnt <= w_len_sum;
        end
    end
`else
    assign w_len_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    case (s_req_func)
                        2'b00:   w_next_state = S_FIRST;
                        2'b01:   w_next_state = S_HDR_ONLY;
                        default: w_next_state = S_IDLE;
                    endcase
                end
            end
            // Header beat is already in the output register; wait for it to leave
            S_HDR_ONLY: begin
                if (m_axis_tready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_FIRST, S_BODY: begin
                if (w_pay_fire) begin
                    if (s_axis_tlast && w_rest_empty) begin
                        w_next_state = S_IDLE;
                    end else if (s_axis_tlast) begin
                        w_next_state = S_TAIL;
                    end else begin
                        w_next_state = S_BODY;
                    end
                end
            end
            S_TAIL: begin
                if (w_slot) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        s_req_ready       = 1'b0;
        s_axis_tready     = 1'b0;
        status_frame_done = r_m_tvalid && m_axis_tready && r_m_tlast;
        if (!rst) begin
            // New request only once the previous frame's last beat has left
            s_req_ready   = (r_state == S_IDLE) && !r_m_tvalid;
            s_axis_tready = ((r_state == S_FIRST) || (r_state == S_BODY)) && w_slot;
        end
    end

    // Request latch, payload carry-over and output beat register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eth       <= '0;
            r_recon     <= '0;
            r_save      <= '0;
            r_save_keep <= '0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= (w_req_fire && s_req_func[1]) || w_len_err;
            if (w_slot) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_req_fire) begin
                r_eth   <= s_req_eth_hdr;
                r_recon <= w_recon_in;
            end
            if (w_pay_fire) begin
                r_save      <= s_axis_tdata[DATA_WIDTH-1:c_SPILL_BITS];
                r_save_keep <= s_axis_tkeep[KEEP_WIDTH-1:c_SPILL_BYTES];
            end
            case (r_state)
                // Header-only frames load straight from the request for 1-cycle latency
                S_IDLE: begin
                    if (w_req_fire && (s_req_func == 2'b01)) begin
                        r_m_tdata  <= {{c_SPILL_BITS{1'b0}}, w_recon_in, s_req_eth_hdr};
                        r_m_tkeep  <= {{c_SPILL_BYTES{1'b0}}, {c_HDR_BYTES{1'b1}}};
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= 1'b1;
                    end
                end
                S_FIRST: begin
                    if (w_pay_fire) begin
                        r_m_tdata  <= {s_axis_tdata[c_SPILL_BITS-1:0], r_recon, r_eth};
                        r_m_tkeep  <= {s_axis_tkeep[c_SPILL_BYTES-1:0], {c_HDR_BYTES{1'b1}}};
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= s_axis_tlast && w_rest_empty;
                    end
                end
                S_BODY: begin
                    if (w_pay_fire) begin
                        r_m_tdata  <= {s_axis_tdata[c_SPILL_BITS-1:0], r_save};
                        r_m_tkeep  <= {s_axis_tkeep[c_SPILL_BYTES-1:0], r_save_keep};
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= s_axis_tlast && w_rest_empty;
                    end
                end
                S_TAIL: begin
                    if (w_slot) begin
                        r_m_tdata  <= {{c_SPILL_BITS{1'b0}}, r_save};
                        r_m_tkeep  <= {{c_SPILL_BYTES{1'b0}}, r_save_keep};
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign status_err    = r_err;

endmodule
`default_nettype wire
